// File: rtl/uart_tx_word_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_word_ser_pkg
// Purpose  : Shared types and constants for the word-serialising UART
//            transmitter: FSM state encoding, parity mode encoding and
//            baud divider width.
// Ports    : none (package)
// Config   : UART_TX_PARITY_EN (consumed by the top; types always present)
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_word_ser_pkg;

  localparam int DIV_WIDTH = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  // A parity bit is only inserted for the two real parity modes.
  function automatic logic parity_active(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_word_ser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_word_ser_if
// Purpose  : Word write bus and status of the UART transmitter.
// Signals  : wren      - write strobe (master -> slave)
//            w_data    - word to transmit (master -> slave)
//            tx_full   - word FIFO full (slave -> master)
//            tx_empty  - word FIFO empty (slave -> master)
//            busy      - transmitter FSM active (slave -> master)
//            overflow  - sticky dropped-write flag (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_word_ser_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  wren;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  busy;
  logic                  overflow;

  modport master (
    output wren, w_data,
    input  tx_full, tx_empty, busy, overflow
  );

  modport slave (
    input  wren, w_data,
    output tx_full, tx_empty, busy, overflow
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_word_ser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous word FIFO feeding the UART transmitter.
// Ports    : clk   - system clock
//            reset - synchronous active-high reset (pointers/count only)
//            push  - write din (ignored while full)
//            pop   - advance read pointer (ignored while empty)
//            din   - write data
//            dout  - head-of-queue word (valid while !empty)
//            full  - FIFO_DEPTH words stored
//            empty - no words stored
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]        cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only read behind the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_word_ser.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_word_ser
// Purpose  : FIFO-buffered UART transmitter. Each DATA_WIDTH-bit word is
//            sent as DATA_WIDTH/FRAME_BITS frames, least-significant frame
//            first, with runtime 1/2 stop bits and optional parity.
// Ports    : clk         - system clock, rising edge
//            reset       - synchronous active-high reset
//            bus         - write bus + status (slave modport)
//            divisor     - baud divider, one tick per divisor+1 cycles
//            parity_mode - 00/11 none, 01 even, 10 odd
//            two_stop    - 0: one stop bit, 1: two stop bits
//            tx          - serial output, idle high, registered
// Config   : UART_TX_PARITY_EN - when defined, a parity bit follows the
//            data bits according to parity_mode; otherwise parity_mode is
//            ignored and frames are start + data + stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_word_ser
  import uart_tx_word_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_BITS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NTICKS     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_word_ser_if.slave    bus,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx
);

  localparam int NFRAMES = DATA_WIDTH / FRAME_BITS;
  localparam int FRM_W   = $clog2(NFRAMES) + 1;
  localparam int BIT_W   = $clog2(FRAME_BITS);
  localparam int TICK_W  = $clog2(NTICKS);

  // FIFO
  logic                  fifo_full, fifo_empty, fifo_push, pop;
  logic [DATA_WIDTH-1:0] fifo_dout;

  // Full is judged on the registered count, so a write while full is
  // dropped even if the FSM pops in the same cycle.
  assign fifo_push = bus.wren && !fifo_full;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (bus.w_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State
  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRM_W-1:0]      frame_q, frame_d;
  logic                  stop_q, stop_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q, overflow_d;
  logic                  load;
  logic                  tick, bit_done;
  logic                  parity_on;

`ifdef UART_TX_PARITY_EN
  parity_e               par_mode_q, par_mode_d;
  logic                  par_acc_q, par_acc_d;
  assign parity_on = parity_active(par_mode_q);
`else
  logic                  unused_parity;
  assign unused_parity = ^parity_mode;
  assign parity_on     = 1'b0;
`endif

  assign tick     = (div_cnt_q == div_lat_q);
  assign bit_done = tick && (tick_q == TICK_W'(NTICKS - 1));

  assign tx           = tx_q;
  assign bus.tx_full  = fifo_full;
  assign bus.tx_empty = fifo_empty;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_lat_d  = div_lat_q;
    div_cnt_d  = div_cnt_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    stop_d     = stop_q;
    two_stop_d = two_stop_q;
    overflow_d = overflow_q || (bus.wren && fifo_full);
    load       = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_mode_d = par_mode_q;
    par_acc_d  = par_acc_q;
`endif

    // Baud generation runs only while a word is in flight.
    if (state_q != IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        tick_d = bit_done ? '0 : tick_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = DATA;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_acc_d = 1'b0;
`endif
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
          par_acc_d = par_acc_q ^ shift_q[0];
`endif
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_d   = '0;
            stop_d  = 1'b0;
            state_d = parity_on ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        // Accumulator holds the XOR of the frame's data bits.
        tx_d = (par_mode_q == PAR_ODD) ? ~par_acc_q : par_acc_q;
        if (bit_done) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (two_stop_q && !stop_q) begin
            stop_d = 1'b1;
          end else if (frame_q != FRM_W'(NFRAMES - 1)) begin
            frame_d = frame_q + 1'b1;
            state_d = START;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Word load: configuration is captured here and held for the whole word.
    if (load) begin
      pop        = 1'b1;
      shift_d    = fifo_dout;
      div_lat_d  = divisor;
      two_stop_d = two_stop;
      div_cnt_d  = '0;
      tick_d     = '0;
      bit_d      = '0;
      frame_d    = '0;
      state_d    = START;
`ifdef UART_TX_PARITY_EN
      par_mode_d = parity_e'(parity_mode);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_lat_q  <= '0;
      div_cnt_q  <= '0;
      tick_q     <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      stop_q     <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_mode_q <= PAR_NONE;
      par_acc_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_lat_q  <= div_lat_d;
      div_cnt_q  <= div_cnt_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      stop_q     <= stop_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      par_mode_q <= par_mode_d;
      par_acc_q  <= par_acc_d;
`endif
    end
  end

endmodule
`default_nettype wire
